// File: rtl/rv_pkg.sv
// Shared RV32M definitions: operation encodings (funct3), muldiv FSM states and default width.
package rv_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } muldiv_state_e;

endpackage

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, sign fix-up in a final cycle. Divide-by-zero and signed overflow take a fast path.
module rv32m_muldiv
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  muldiv_state_e     state;
  muldiv_op_e        op;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic [CW-1:0]     cnt;
  logic              sa, sb, fast;
  logic [4:0]        rd_lat;

  assign busy = (state != IDLE);

  // Operand decode at acceptance
  muldiv_op_e      op_in;
  logic            a_signed, b_signed, sa_in, sb_in, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_val;

  always_comb begin
    op_in    = muldiv_op_e'(funct3);
    a_signed = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    b_signed = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    sa_in    = a_signed & op_a[XLEN-1];
    sb_in    = b_signed & op_b[XLEN-1];
    a_mag    = sa_in ? (~op_a + 1'b1) : op_a;
    b_mag    = sb_in ? (~op_b + 1'b1) : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    fast_val = '0;
    if (div_zero)     fast_val = funct3[1] ? op_a : '1;
    else if (div_ovf) fast_val = funct3[1] ? '0 : op_a;
  end

  // One iteration of each algorithm
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    // Partial remainder shifted left with the next dividend bit; a borrow means restore
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opb};
    div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    prod_fix = (sa ^ sb) ? (~acc + 1'b1) : acc;
    quo_fix  = (sa ^ sb) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix  = sa ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    fix_val  = '0;
    if (fast) fix_val = acc[XLEN-1:0];
    else begin
      case (op)
        OP_MUL:                      fix_val = prod_fix[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:             fix_val = quo_fix;
        default:                     fix_val = rem_fix;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op     <= OP_MUL;
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      fast   <= 1'b0;
      rd_lat <= '0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            op     <= op_in;
            rd_lat <= rd_in;
            cnt    <= '0;
            fast   <= div_zero | div_ovf;
            if (div_zero | div_ovf) begin
              sa    <= 1'b0;
              sb    <= 1'b0;
              acc   <= {{XLEN{1'b0}}, fast_val};
              opb   <= '0;
              state <= FIX;
            end else begin
              sa    <= sa_in;
              sb    <= sb_in;
              acc   <= {{XLEN{1'b0}}, a_mag};
              opb   <= b_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) state <= IDLE;
          else begin
            acc <= op[2] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (kill) state <= IDLE;
          else begin
            result <= fix_val;
            rd_out <= rd_lat;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
